// File: rtl/md_unit_if.sv
// Request/response bundle between the E-stage control decoder and the
// multiply/divide unit: launch request, operands, direct HI/LO writes and
// the busy flag plus HI/LO register values returned to the pipeline.
interface md_unit_if;
  logic        start;
  logic [2:0]  mdctr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hiwrite;
  logic        lowrite;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Decoder side: issues requests, observes busy and HI/LO.
  modport master (
    output start, mdctr, rs_val, rt_val, hiwrite, lowrite,
    input  busy, hi, lo
  );

  // Unit side: consumes requests, drives busy and HI/LO.
  modport slave (
    input  start, mdctr, rs_val, rt_val, hiwrite, lowrite,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit. The 64-bit result is computed on the
// launch edge and parked in pend_hi/pend_lo; the unit then stays busy for a
// fixed latency and commits to HI/LO on the last busy edge, so the new values
// appear in the first cycle busy is low. mthi/mtlo write HI/LO directly while
// idle.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] MULT_LAT = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LAT  = 8'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic        op_valid_s;
  logic        op_div_s;
  logic        op_signed_s;

  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic        neg_a_s, neg_b_s, div_zero_s;
  logic [31:0] mag_a_s, mag_b_s, safe_b_s;
  logic [31:0] q_mag_s, r_mag_s, quot_s, rem_s;

  // Decode the requested operation class and signedness.
  always_comb begin
    op_valid_s  = 1'b0;
    op_div_s    = 1'b0;
    op_signed_s = 1'b0;
    case (md.mdctr)
      3'b001: begin op_valid_s = 1'b1; op_div_s = 1'b0; op_signed_s = 1'b1; end
      3'b010: begin op_valid_s = 1'b1; op_div_s = 1'b0; op_signed_s = 1'b0; end
      3'b011: begin op_valid_s = 1'b1; op_div_s = 1'b1; op_signed_s = 1'b1; end
      3'b100: begin op_valid_s = 1'b1; op_div_s = 1'b1; op_signed_s = 1'b0; end
      default: begin op_valid_s = 1'b0; op_div_s = 1'b0; op_signed_s = 1'b0; end
    endcase
  end

  // Product and quotient/remainder of the current operands.
  // Division runs on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // without relying on simulator behaviour for signed overflow; a zero
  // divisor is replaced by 1 to keep the datapath free of X, and its result
  // is discarded anyway.
  always_comb begin
    mul_a_s = op_signed_s ? {{32{md.rs_val[31]}}, md.rs_val} : {32'd0, md.rs_val};
    mul_b_s = op_signed_s ? {{32{md.rt_val[31]}}, md.rt_val} : {32'd0, md.rt_val};
    prod_s  = mul_a_s * mul_b_s;

    neg_a_s    = op_signed_s & md.rs_val[31];
    neg_b_s    = op_signed_s & md.rt_val[31];
    mag_a_s    = neg_a_s ? (32'd0 - md.rs_val) : md.rs_val;
    mag_b_s    = neg_b_s ? (32'd0 - md.rt_val) : md.rt_val;
    div_zero_s = (md.rt_val == 32'd0);
    safe_b_s   = div_zero_s ? 32'd1 : mag_b_s;
    q_mag_s    = mag_a_s / safe_b_s;
    r_mag_s    = mag_a_s % safe_b_s;
    quot_s     = (neg_a_s ^ neg_b_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s      = neg_a_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Next-state logic: launch, latency countdown, commit and direct writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start && op_valid_s) begin
          // A valid launch wins; any concurrent mthi/mtlo is dropped.
          state_d = ST_BUSY;
          if (op_div_s) begin
            cnt_d = DIV_LAT;
            if (div_zero_s) begin
              pend_hi_d = hi_q;
              pend_lo_d = lo_q;
            end else begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
            end
          end else begin
            cnt_d     = MULT_LAT;
            pend_hi_d = prod_s[63:32];
            pend_lo_d = prod_s[31:0];
          end
        end else begin
          if (md.hiwrite) begin
            hi_d = md.rs_val;
          end else begin
            hi_d = hi_q;
          end
          if (md.lowrite) begin
            lo_d = md.rs_val;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      ST_BUSY: begin
        // Requests arriving here are ignored; the op in flight runs out.
        if (cnt_q == 8'd0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign md.busy = (state_q == ST_BUSY);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: inputs change 1 ns after the rising edge and
// outputs are checked at the same point, i.e. well away from the edge.
module tb_md_unit;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  md_unit_if mdi ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdi.start  = 1'b1;
    mdi.mdctr  = op;
    mdi.rs_val = a;
    mdi.rt_val = b;
    tick();
    mdi.start  = 1'b0;
    mdi.mdctr  = 3'b000;
  endtask

  // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (mdi.busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (mdi.busy !== 1'b0) $display("FAIL reset_busy got %h exp 0", mdi.busy); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_mult();
    int n;
    launch(3'b001, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    total_cnt++; if (n != 5) $display("FAIL mult_lat got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h exp fffffff1", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_multu();
    int n;
    launch(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    total_cnt++; if (n != 5) $display("FAIL multu_lat got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h exp fffffffe", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h exp 00000001", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_div();
    int n;
    launch(3'b011, 32'hFFFF_FFF9, 32'd2);
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFE) $display("FAIL div_hi_held got %h exp fffffffe", mdi.hi); else pass_cnt++;
    wait_idle(n);
    total_cnt++; if (n != 10) $display("FAIL div_lat got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", mdi.hi); else pass_cnt++;
    launch(3'b100, 32'd7, 32'd0);
    wait_idle(n);
    total_cnt++; if (n != 10) $display("FAIL divu0_lat got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'hFFFF_FFFD) $display("FAIL divu0_lo got %h exp fffffffd", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFF) $display("FAIL divu0_hi got %h exp ffffffff", mdi.hi); else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [2:0] ops [3];
    ops[0] = 3'b000; ops[1] = 3'b101; ops[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      launch(ops[i], 32'd9, 32'd3);
      total_cnt++; if (mdi.busy !== 1'b0) $display("FAIL invalid_busy op %b got %h exp 0", ops[i], mdi.busy); else pass_cnt++;
    end
    total_cnt++; if (mdi.hi !== 32'hFFFF_FFFF) $display("FAIL invalid_hi got %h exp ffffffff", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'hFFFF_FFFD) $display("FAIL invalid_lo got %h exp fffffffd", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int n;
    launch(3'b001, 32'd3, 32'd4);
    mdi.hiwrite = 1'b1;
    mdi.lowrite = 1'b1;
    mdi.start   = 1'b1;
    mdi.mdctr   = 3'b011;
    mdi.rs_val  = 32'hDEAD;
    mdi.rt_val  = 32'd1;
    tick();
    tick();
    mdi.hiwrite = 1'b0;
    mdi.lowrite = 1'b0;
    mdi.start   = 1'b0;
    mdi.mdctr   = 3'b000;
    wait_idle(n);
    total_cnt++; if (n != 3) $display("FAIL ignore_lat got %0d exp 3", n); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL ignore_hi got %h exp 0", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'd12) $display("FAIL ignore_lo got %h exp c", mdi.lo); else pass_cnt++;
    mdi.hiwrite = 1'b1;
    mdi.rs_val  = 32'hABCD;
    tick();
    mdi.hiwrite = 1'b0;
    total_cnt++; if (mdi.hi !== 32'hABCD) $display("FAIL mthi_hi got %h exp abcd", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'd12) $display("FAIL mthi_lo got %h exp c", mdi.lo); else pass_cnt++;
    mdi.hiwrite = 1'b1;
    mdi.lowrite = 1'b1;
    mdi.rs_val  = 32'h5555_AAAA;
    tick();
    mdi.hiwrite = 1'b0;
    mdi.lowrite = 1'b0;
    total_cnt++; if (mdi.hi !== 32'h5555_AAAA) $display("FAIL mthilo_hi got %h exp 5555aaaa", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'h5555_AAAA) $display("FAIL mthilo_lo got %h exp 5555aaaa", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_priority();
    int n;
    mdi.hiwrite = 1'b1;
    mdi.lowrite = 1'b1;
    launch(3'b001, 32'h10, 32'h10);
    mdi.hiwrite = 1'b0;
    mdi.lowrite = 1'b0;
    total_cnt++; if (mdi.busy !== 1'b1) $display("FAIL prio_busy got %h exp 1", mdi.busy); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'h5555_AAAA) $display("FAIL prio_hi_held got %h exp 5555aaaa", mdi.hi); else pass_cnt++;
    wait_idle(n);
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL prio_hi got %h exp 0", mdi.hi); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'h100) $display("FAIL prio_lo got %h exp 100", mdi.lo); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    launch(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    total_cnt++; if (n != 10) $display("FAIL b2b_div_lat got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'h8000_0000) $display("FAIL b2b_div_lo got %h exp 80000000", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL b2b_div_hi got %h exp 0", mdi.hi); else pass_cnt++;
    launch(3'b010, 32'd2, 32'd3);
    total_cnt++; if (mdi.busy !== 1'b1) $display("FAIL b2b_accept got %h exp 1", mdi.busy); else pass_cnt++;
    wait_idle(n);
    total_cnt++; if (n != 5) $display("FAIL b2b_mul_lat got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'd6) $display("FAIL b2b_mul_lo got %h exp 6", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL b2b_mul_hi got %h exp 0", mdi.hi); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    launch(3'b011, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b0;
    #1;
    total_cnt++; if (mdi.busy !== 1'b0) $display("FAIL rstmid_busy got %h exp 0", mdi.busy); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'd0) $display("FAIL rstmid_lo got %h exp 0", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL rstmid_hi got %h exp 0", mdi.hi); else pass_cnt++;
    tick();
    reset = 1'b1;
    repeat (15) tick();
    total_cnt++; if (mdi.busy !== 1'b0) $display("FAIL rstmid_late_busy got %h exp 0", mdi.busy); else pass_cnt++;
    total_cnt++; if (mdi.lo !== 32'd0) $display("FAIL rstmid_late_lo got %h exp 0", mdi.lo); else pass_cnt++;
    total_cnt++; if (mdi.hi !== 32'd0) $display("FAIL rstmid_late_hi got %h exp 0", mdi.hi); else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset       = 1'b0;
    mdi.start   = 1'b0;
    mdi.mdctr   = 3'b000;
    mdi.rs_val  = 32'd0;
    mdi.rt_val  = 32'd0;
    mdi.hiwrite = 1'b0;
    mdi.lowrite = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_invalid();
    test_busy_ignore();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
